alu_basic_setup: RTL and testbench

//  6502-style ALU datapath slice: A/B input latches, ALU (SUM/AND/EOR/OR/SR, optional decimal adjust),

---
 rtl/alu_basic_setup.sv | 205 ++++++++++++++++++++
 tb/tb_alu_basic_setup.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_basic_setup.sv
// alu_basic_setup: 8-bit 6502-style ALU datapath slice.
// A/B input latches feed a combinational ALU (SUM with optional BCD adjust,
// AND, EOR, OR, shift-right). The result and flags are captured in a hold
// register that can drive the internal SB and ADL buses. Dummy drivers let
// a bench inject values onto DB, SB and ADL.
// Buses resolve as a wired-AND of all enabled drivers. A bit that nothing
// drives floats to the precharge level dummy_HIGH.

module alu_basic_setup (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SB_TO_A,
    input  logic       ZERO_A,
    input  logic       DB_TO_B,
    input  logic       NOT_DB_TO_B,
    input  logic       ADL_TO_B,
    input  logic       sig_DAA,
    input  logic       sig_CARRY_IN,
    input  logic       sig_SUMS,
    input  logic       sig_ANDS,
    input  logic       sig_EORS,
    input  logic       sig_ORS,
    input  logic       sig_SRS,
    input  logic       ALU_TO_HOLD,
    input  logic       HOLD_TO_ADL,
    input  logic       HOLD_L_TO_SB,
    input  logic       HOLD_H_TO_SB,
    input  logic       dummy_HIGH,
    input  logic       force_DB,
    input  logic       force_SB,
    input  logic       force_ADL,
    input  logic [7:0] DUMMY_DB,
    input  logic [7:0] DUMMY_SB,
    input  logic [7:0] DUMMY_ADL,
    output logic [7:0] DB,
    output logic [7:0] SB,
    output logic [7:0] ADL,
    output logic       AVR_OUT,
    output logic       ACR_OUT,
    output logic       HC_OUT
);

    // Resolve one bus bit: wired-AND of enabled drivers, precharge if none.
    function automatic logic resolve_bit(input logic [2:0] en,
                                         input logic [2:0] val,
                                         input logic       pre);
        logic wand_v;
        wand_v = &(val | ~en);
        if (|en) begin
            return wand_v;
        end else begin
            return pre;
        end
    endfunction

    logic [7:0] a_r;
    logic [7:0] b_r;
    logic [7:0] hold_r;
    logic       avr_r;
    logic       acr_r;
    logic       hc_r;

    logic [7:0] db_s;
    logic [7:0] sb_s;
    logic [7:0] adl_s;

    logic [4:0] lo5_s;
    logic [8:0] sum9_s;
    logic       bin_avr_s;
    logic       low_adj_s;
    logic [9:0] dec1_s;
    logic       hi_adj_s;
    logic [7:0] dec_res_s;
    logic [7:0] alu_res_s;
    logic       alu_avr_s;
    logic       alu_acr_s;
    logic       alu_hc_s;

    // Bus resolution for DB, SB and ADL, bit by bit.
    always_comb begin
        db_s  = 8'h00;
        sb_s  = 8'h00;
        adl_s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            db_s[i]  = resolve_bit({force_DB, 1'b0, 1'b0},
                                   {DUMMY_DB[i], 1'b1, 1'b1}, dummy_HIGH);
            adl_s[i] = resolve_bit({force_ADL, HOLD_TO_ADL, 1'b0},
                                   {DUMMY_ADL[i], hold_r[i], 1'b1}, dummy_HIGH);
            if (i == 7) begin
                sb_s[i] = resolve_bit({force_SB, HOLD_H_TO_SB, 1'b0},
                                      {DUMMY_SB[i], hold_r[i], 1'b1}, dummy_HIGH);
            end else begin
                sb_s[i] = resolve_bit({force_SB, HOLD_L_TO_SB, 1'b0},
                                      {DUMMY_SB[i], hold_r[i], 1'b1}, dummy_HIGH);
            end
        end
    end

    assign DB  = db_s;
    assign SB  = sb_s;
    assign ADL = adl_s;

    // Binary sum, half carry, overflow and the two-stage BCD adjust.
    always_comb begin
        lo5_s     = {1'b0, a_r[3:0]} + {1'b0, b_r[3:0]} + {4'b0000, sig_CARRY_IN};
        sum9_s    = {1'b0, a_r} + {1'b0, b_r} + {8'h00, sig_CARRY_IN};
        bin_avr_s = (a_r[7] == b_r[7]) && (sum9_s[7] != a_r[7]);
        // Low-nibble correction comes first; the high-nibble test sees its carry.
        low_adj_s = (sum9_s[3:0] > 4'd9) || lo5_s[4];
        if (low_adj_s) begin
            dec1_s = {1'b0, sum9_s} + 10'd6;
        end else begin
            dec1_s = {1'b0, sum9_s};
        end
        hi_adj_s = (dec1_s[7:4] > 4'd9) || (dec1_s[9:8] != 2'b00);
        if (hi_adj_s) begin
            dec_res_s = dec1_s[7:0] + 8'h60;
        end else begin
            dec_res_s = dec1_s[7:0];
        end
    end

    // Operation select with fixed priority SUMS > ANDS > EORS > ORS > SRS.
    always_comb begin
        alu_res_s = 8'h00;
        alu_avr_s = 1'b0;
        alu_acr_s = 1'b0;
        alu_hc_s  = 1'b0;
        if (sig_SUMS) begin
            alu_avr_s = bin_avr_s;
            alu_hc_s  = lo5_s[4];
            if (sig_DAA) begin
                alu_res_s = dec_res_s;
                alu_acr_s = hi_adj_s;
            end else begin
                alu_res_s = sum9_s[7:0];
                alu_acr_s = sum9_s[8];
            end
        end else if (sig_ANDS) begin
            alu_res_s = a_r & b_r;
        end else if (sig_EORS) begin
            alu_res_s = a_r ^ b_r;
        end else if (sig_ORS) begin
            alu_res_s = a_r | b_r;
        end else if (sig_SRS) begin
            alu_res_s = {sig_CARRY_IN, a_r[7:1]};
            alu_acr_s = a_r[0];
        end else begin
            alu_res_s = 8'h00;
        end
    end

    // A input latch: clear wins over load from SB (pre-edge bus value).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= 8'h00;
        end else if (ZERO_A) begin
            a_r <= 8'h00;
        end else if (SB_TO_A) begin
            a_r <= sb_s;
        end else begin
            a_r <= a_r;
        end
    end

    // B input latch: DB, then inverted DB, then ADL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_r <= 8'h00;
        end else if (DB_TO_B) begin
            b_r <= db_s;
        end else if (NOT_DB_TO_B) begin
            b_r <= ~db_s;
        end else if (ADL_TO_B) begin
            b_r <= adl_s;
        end else begin
            b_r <= b_r;
        end
    end

    // Hold register and flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r <= 8'h00;
            avr_r  <= 1'b0;
            acr_r  <= 1'b0;
            hc_r   <= 1'b0;
        end else if (ALU_TO_HOLD) begin
            hold_r <= alu_res_s;
            avr_r  <= alu_avr_s;
            acr_r  <= alu_acr_s;
            hc_r   <= alu_hc_s;
        end else begin
            hold_r <= hold_r;
            avr_r  <= avr_r;
            acr_r  <= acr_r;
            hc_r   <= hc_r;
        end
    end

    assign AVR_OUT = avr_r;
    assign ACR_OUT = acr_r;
    assign HC_OUT  = hc_r;

endmodule

// File: tb/tb_alu_basic_setup.sv
// Directed bench for alu_basic_setup: table of ALU vectors plus hand-written
// sequences for reset, bus contention, B-source priority and SB feedback.

module tb_alu_basic_setup;

    logic       clk;
    logic       rst_n;
    logic       SB_TO_A, ZERO_A, DB_TO_B, NOT_DB_TO_B, ADL_TO_B;
    logic       sig_DAA, sig_CARRY_IN;
    logic       sig_SUMS, sig_ANDS, sig_EORS, sig_ORS, sig_SRS;
    logic       ALU_TO_HOLD, HOLD_TO_ADL, HOLD_L_TO_SB, HOLD_H_TO_SB;
    logic       dummy_HIGH, force_DB, force_SB, force_ADL;
    logic [7:0] DUMMY_DB, DUMMY_SB, DUMMY_ADL;
    logic [7:0] DB, SB, ADL;
    logic       AVR_OUT, ACR_OUT, HC_OUT;

    int checks;
    int errors;

    alu_basic_setup dut (
        .clk(clk), .rst_n(rst_n),
        .SB_TO_A(SB_TO_A), .ZERO_A(ZERO_A), .DB_TO_B(DB_TO_B),
        .NOT_DB_TO_B(NOT_DB_TO_B), .ADL_TO_B(ADL_TO_B),
        .sig_DAA(sig_DAA), .sig_CARRY_IN(sig_CARRY_IN),
        .sig_SUMS(sig_SUMS), .sig_ANDS(sig_ANDS), .sig_EORS(sig_EORS),
        .sig_ORS(sig_ORS), .sig_SRS(sig_SRS),
        .ALU_TO_HOLD(ALU_TO_HOLD), .HOLD_TO_ADL(HOLD_TO_ADL),
        .HOLD_L_TO_SB(HOLD_L_TO_SB), .HOLD_H_TO_SB(HOLD_H_TO_SB),
        .dummy_HIGH(dummy_HIGH), .force_DB(force_DB), .force_SB(force_SB),
        .force_ADL(force_ADL), .DUMMY_DB(DUMMY_DB), .DUMMY_SB(DUMMY_SB),
        .DUMMY_ADL(DUMMY_ADL), .DB(DB), .SB(SB), .ADL(ADL),
        .AVR_OUT(AVR_OUT), .ACR_OUT(ACR_OUT), .HC_OUT(HC_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ops: [4]=SUMS [3]=ANDS [2]=EORS [1]=ORS [0]=SRS
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       inv_b;
        logic [4:0] ops;
        logic       cin;
        logic       daa;
        logic [7:0] exp_res;
        logic       exp_avr;
        logic       exp_acr;
        logic       exp_hc;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        SB_TO_A = 1'b0; ZERO_A = 1'b0; DB_TO_B = 1'b0; NOT_DB_TO_B = 1'b0;
        ADL_TO_B = 1'b0; sig_DAA = 1'b0; sig_CARRY_IN = 1'b0;
        sig_SUMS = 1'b0; sig_ANDS = 1'b0; sig_EORS = 1'b0; sig_ORS = 1'b0;
        sig_SRS = 1'b0; ALU_TO_HOLD = 1'b0; HOLD_TO_ADL = 1'b0;
        HOLD_L_TO_SB = 1'b0; HOLD_H_TO_SB = 1'b0; dummy_HIGH = 1'b1;
        force_DB = 1'b0; force_SB = 1'b0; force_ADL = 1'b0;
        DUMMY_DB = 8'h00; DUMMY_SB = 8'h00; DUMMY_ADL = 8'h00;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic set_ops(input logic [4:0] ops);
        sig_SUMS = ops[4]; sig_ANDS = ops[3]; sig_EORS = ops[2];
        sig_ORS = ops[1]; sig_SRS = ops[0];
    endtask

    // Load A from SB and B from DB (or ~DB) on one edge, capture on the next.
    task automatic load_and_op(input logic [7:0] a, input logic [7:0] b, input logic inv_b,
                               input logic [4:0] ops, input logic cin, input logic daa);
        idle();
        force_SB = 1'b1; DUMMY_SB = a; SB_TO_A = 1'b1;
        force_DB = 1'b1; DUMMY_DB = b;
        DB_TO_B = ~inv_b; NOT_DB_TO_B = inv_b;
        tick();
        idle();
        set_ops(ops); sig_CARRY_IN = cin; sig_DAA = daa; ALU_TO_HOLD = 1'b1;
        tick();
        idle();
    endtask

    task automatic read_hold(input string name, input logic [7:0] exp);
        idle();
        HOLD_TO_ADL = 1'b1;
        #1;
        check8(name, ADL, exp);
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{8'h50, 8'h50, 1'b0, 5'b10000, 1'b0, 1'b0, 8'hA0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{8'h19, 8'h28, 1'b0, 5'b10000, 1'b0, 1'b1, 8'h47, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{8'h99, 8'h01, 1'b0, 5'b10000, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{8'hF0, 8'h3C, 1'b1, 5'b01000, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{8'hF0, 8'h3C, 1'b1, 5'b00100, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'hF0, 8'h3C, 1'b1, 5'b00010, 1'b0, 1'b0, 8'hF3, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'hFF, 8'h01, 1'b0, 5'b10000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{8'h7F, 8'h00, 1'b0, 5'b10000, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{8'h80, 8'h80, 1'b0, 5'b10000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{8'h12, 8'h34, 1'b0, 5'b00000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{8'h01, 8'h02, 1'b0, 5'b11111, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{8'hF0, 8'h3C, 1'b0, 5'b01100, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{8'h81, 8'h00, 1'b0, 5'b00001, 1'b1, 1'b0, 8'hC0, 1'b0, 1'b1, 1'b0};

        // Reset state
        idle();
        rst_n = 1'b0;
        HOLD_TO_ADL = 1'b1;
        #3;
        check8("reset_adl", ADL, 8'h00);
        check1("reset_avr", AVR_OUT, 1'b0);
        check1("reset_acr", ACR_OUT, 1'b0);
        check1("reset_hc", HC_OUT, 1'b0);
        tick();
        rst_n = 1'b1;
        idle();
        tick();

        // Table-driven ALU vectors
        for (int i = 0; i < NVEC; i++) begin
            load_and_op(vecs[i].a, vecs[i].b, vecs[i].inv_b, vecs[i].ops,
                        vecs[i].cin, vecs[i].daa);
            read_hold($sformatf("vec%0d_res", i), vecs[i].exp_res);
            check1($sformatf("vec%0d_avr", i), AVR_OUT, vecs[i].exp_avr);
            check1($sformatf("vec%0d_acr", i), ACR_OUT, vecs[i].exp_acr);
            check1($sformatf("vec%0d_hc", i), HC_OUT, vecs[i].exp_hc);
        end

        // ZERO_A beats SB_TO_A; SRS with CIN=0 then clears ACR left set above
        idle();
        force_SB = 1'b1; DUMMY_SB = 8'hFF; SB_TO_A = 1'b1; ZERO_A = 1'b1;
        tick();
        idle();
        sig_SRS = 1'b1; ALU_TO_HOLD = 1'b1;
        tick();
        read_hold("zero_a_srs_res", 8'h00);
        check1("zero_a_srs_acr", ACR_OUT, 1'b0);

        // Hold retains when ALU_TO_HOLD is low
        load_and_op(8'h22, 8'h11, 1'b0, 5'b10000, 1'b0, 1'b0);
        idle();
        force_SB = 1'b1; DUMMY_SB = 8'h77; SB_TO_A = 1'b1; sig_SUMS = 1'b1;
        tick();
        tick();
        read_hold("hold_retain", 8'h33);

        // B from ADL, then DB_TO_B outranks ADL_TO_B
        idle();
        force_SB = 1'b1; DUMMY_SB = 8'h22; SB_TO_A = 1'b1;
        force_ADL = 1'b1; DUMMY_ADL = 8'h11; ADL_TO_B = 1'b1;
        tick();
        idle(); sig_SUMS = 1'b1; ALU_TO_HOLD = 1'b1;
        tick();
        read_hold("b_from_adl", 8'h33);
        idle();
        force_DB = 1'b1; DUMMY_DB = 8'h01; DB_TO_B = 1'b1;
        force_ADL = 1'b1; DUMMY_ADL = 8'h11; ADL_TO_B = 1'b1;
        tick();
        idle(); sig_SUMS = 1'b1; ALU_TO_HOLD = 1'b1;
        tick();
        read_hold("b_db_priority", 8'h23);

        // Bus contention and precharge
        load_and_op(8'hF5, 8'h00, 1'b0, 5'b00010, 1'b0, 1'b0);
        force_SB = 1'b1; DUMMY_SB = 8'h0F; HOLD_L_TO_SB = 1'b1; HOLD_H_TO_SB = 1'b1;
        #1;
        check8("sb_wired_and", SB, 8'h05);
        idle();
        HOLD_L_TO_SB = 1'b1; dummy_HIGH = 1'b0;
        #1;
        check8("sb_low_only", SB, 8'h75);
        idle();
        #1;
        check8("sb_precharge", SB, 8'hFF);
        check8("db_precharge", DB, 8'hFF);
        force_DB = 1'b1; DUMMY_DB = 8'h5A;
        #1;
        check8("db_forced", DB, 8'h5A);
        idle();
        force_ADL = 1'b1; DUMMY_ADL = 8'hF0; HOLD_TO_ADL = 1'b1;
        #1;
        check8("adl_wired_and", ADL, 8'hF0);
        idle();

        // SB feedback: A samples the pre-edge bus while hold updates
        load_and_op(8'h05, 8'h00, 1'b0, 5'b10000, 1'b0, 1'b0);
        force_SB = 1'b1; DUMMY_SB = 8'h10; SB_TO_A = 1'b1;
        tick();
        idle();
        HOLD_L_TO_SB = 1'b1; HOLD_H_TO_SB = 1'b1; SB_TO_A = 1'b1;
        sig_SUMS = 1'b1; ALU_TO_HOLD = 1'b1;
        #1;
        check8("feedback_sb_pre", SB, 8'h05);
        tick();
        read_hold("feedback_hold1", 8'h10);
        sig_SUMS = 1'b1; ALU_TO_HOLD = 1'b1;
        tick();
        read_hold("feedback_hold2", 8'h05);

        // Asynchronous reset mid-run, no clock edge needed
        load_and_op(8'hFF, 8'h01, 1'b0, 5'b10000, 1'b0, 1'b0);
        HOLD_TO_ADL = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check8("async_rst_adl", ADL, 8'h00);
        check1("async_rst_acr", ACR_OUT, 1'b0);
        check1("async_rst_hc", HC_OUT, 1'b0);
        rst_n = 1'b1;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
